// File: rtl/mem_access_stage.sv
// Memory-access stage: takes execute results, runs the data-memory load/store over a
// req/ack bus and hands a one-entry buffered result to writeback.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_we,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_we,
  output logic              mem_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [DATA_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic              wb_we_q, wb_we_d;
  logic              mem_fault_q, mem_fault_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  // Destination of the in-flight access, applied when the ack (or abort) lands.
  logic [REG_W-1:0]  pend_rd_q, pend_rd_d;
  logic              pend_we_q, pend_we_d;

  logic accept;
  logic is_mem_op;
  logic op_fault;

  assign ex_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_HOLD) && wb_ready));
  assign accept    = ex_valid && ex_ready;
  assign is_mem_op = ex_mem_rd || ex_mem_wr;
  assign op_fault  = (ex_mem_rd && ex_mem_wr) || (is_mem_op && (ex_alu_result[1:0] != 2'b00));

  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_we_d      = wb_we_q;
    mem_fault_d  = 1'b0;
    tmo_cnt_d    = tmo_cnt_q;
    pend_rd_d    = pend_rd_q;
    pend_we_d    = pend_we_q;

    case (state_q)
      S_MEM: begin
        if (dmem_ack) begin
          state_d    = S_HOLD;
          dmem_req_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = pend_rd_q;
          wb_data_d  = dmem_we_q ? '0 : dmem_rdata;
          wb_we_d    = dmem_we_q ? 1'b0 : pend_we_q;
        end else if (tmo_cnt_q + 16'd1 >= TMO_LIM) begin
          state_d     = S_HOLD;
          dmem_req_d  = 1'b0;
          wb_valid_d  = 1'b1;
          wb_rd_d     = pend_rd_q;
          wb_data_d   = '0;
          wb_we_d     = 1'b0;
          mem_fault_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (wb_ready && !accept) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new op can arrive from IDLE or, back-to-back, while HOLD drains.
    if (accept) begin
      wb_rd_d = ex_rd;
      if (op_fault) begin
        state_d     = S_HOLD;
        wb_valid_d  = 1'b1;
        wb_data_d   = '0;
        wb_we_d     = 1'b0;
        mem_fault_d = 1'b1;
      end else if (is_mem_op) begin
        state_d      = S_MEM;
        dmem_req_d   = 1'b1;
        dmem_we_d    = ex_mem_wr;
        dmem_addr_d  = ex_alu_result;
        dmem_wdata_d = ex_store_data;
        tmo_cnt_d    = '0;
        pend_rd_d    = ex_rd;
        pend_we_d    = ex_reg_we;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
      end else begin
        state_d    = S_HOLD;
        wb_valid_d = 1'b1;
        wb_data_d  = ex_alu_result;
        wb_we_d    = ex_reg_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_we_q      <= 1'b0;
      mem_fault_q  <= 1'b0;
      tmo_cnt_q    <= '0;
      pend_rd_q    <= '0;
      pend_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_we_q      <= wb_we_d;
      mem_fault_q  <= mem_fault_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pend_rd_q    <= pend_rd_d;
      pend_we_q    <= pend_we_d;
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_we      = wb_we_q;
  assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations (TIMEOUT=4).
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_we, ex_mem_rd, ex_mem_wr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, mem_fault;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_we(wb_we), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [4:0] rd, input logic we, input logic mr, input logic mw);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd;
    ex_rd = rd; ex_reg_we = we; ex_mem_rd = mr; ex_mem_wr = mw;
  endtask

  int n;

  initial begin
    rst = 1'b1; wb_ready = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_ex_ready", {31'b0, ex_ready}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_fault", {31'b0, mem_fault}, 32'd0);
    rst = 1'b0; #1;
    chk("idle_ex_ready", {31'b0, ex_ready}, 32'd1);

    // ALU op
    drive_op(1'b1, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("alu_wb_data", wb_data, 32'h1234);
    chk("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
    chk("alu_wb_we", {31'b0, wb_we}, 32'd1);
    chk("alu_no_req", {31'b0, dmem_req}, 32'd0);
    tick();
    chk("alu_drain", {31'b0, wb_valid}, 32'd0);

    // Load, ack on the third request cycle
    drive_op(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("ld_addr", dmem_addr, 32'h100);
    chk("ld_we", {31'b0, dmem_we}, 32'd0);
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      chk("ld_ex_ready", {31'b0, ex_ready}, 32'd0);
      chk("ld_wb_valid_mem", {31'b0, wb_valid}, 32'd0);
      if (n == 3) begin dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF; end
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
    end
    chk("ld_req_cycles", n, 32'd3);
    chk("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("ld_wb_data", wb_data, 32'hDEADBEEF);
    chk("ld_wb_rd", {27'b0, wb_rd}, 32'd7);
    chk("ld_wb_we", {31'b0, wb_we}, 32'd1);
    chk("ld_fault", {31'b0, mem_fault}, 32'd0);
    tick();

    // Aligned store, ack in the first request cycle
    drive_op(1'b1, 32'h40, 32'hCAFEF00D, 5'd9, 1'b1, 1'b0, 1'b1);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("st_req", {31'b0, dmem_req}, 32'd1);
    chk("st_we", {31'b0, dmem_we}, 32'd1);
    chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
    dmem_ack = 1'b1; dmem_rdata = 32'h55555555;
    tick();
    dmem_ack = 1'b0;
    chk("st_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("st_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("st_wb_data", wb_data, 32'h0);
    chk("st_wb_we", {31'b0, wb_we}, 32'd0);
    tick();

    // Misaligned store faults without touching memory
    drive_op(1'b1, 32'h102, 32'h1, 5'd4, 1'b0, 1'b0, 1'b1);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_fault", {31'b0, mem_fault}, 32'd1);
    chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("mis_wb_we", {31'b0, wb_we}, 32'd0);
    tick();
    chk("mis_fault_pulse", {31'b0, mem_fault}, 32'd0);

    // Load and store both set faults
    drive_op(1'b1, 32'h200, 32'h1, 5'd4, 1'b1, 1'b1, 1'b1);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rw_fault", {31'b0, mem_fault}, 32'd1);
    chk("rw_req", {31'b0, dmem_req}, 32'd0);
    tick();

    // Timeout: never acked
    drive_op(1'b1, 32'h300, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      chk("tmo_fault_early", {31'b0, mem_fault}, 32'd0);
      tick();
    end
    chk("tmo_req_cycles", n, 32'd4);
    chk("tmo_fault", {31'b0, mem_fault}, 32'd1);
    chk("tmo_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("tmo_wb_we", {31'b0, wb_we}, 32'd0);
    chk("tmo_wb_data", wb_data, 32'h0);
    tick();

    // Ack arriving on the limit cycle completes normally
    drive_op(1'b1, 32'h304, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      if (n == 4) begin dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D; end
      tick();
      dmem_ack = 1'b0;
    end
    chk("lim_req_cycles", n, 32'd4);
    chk("lim_fault", {31'b0, mem_fault}, 32'd0);
    chk("lim_wb_data", wb_data, 32'h0BADF00D);
    chk("lim_wb_we", {31'b0, wb_we}, 32'd1);
    tick();

    // Back-pressure then back-to-back ALU ops
    wb_ready = 1'b0;
    drive_op(1'b1, 32'hAAAA, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive_op(1'b1, 32'h1111, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_ex_ready", {31'b0, ex_ready}, 32'd0);
      chk("bp_wb_data", wb_data, 32'hAAAA);
      chk("bp_wb_rd", {27'b0, wb_rd}, 32'd3);
      tick();
    end
    wb_ready = 1'b1; #1;
    chk("bp_release_ready", {31'b0, ex_ready}, 32'd1);
    tick();
    chk("b2b_1", wb_data, 32'h1111);
    chk("b2b_1v", {31'b0, wb_valid}, 32'd1);
    drive_op(1'b1, 32'h2222, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_2", wb_data, 32'h2222);
    chk("b2b_2v", {31'b0, wb_valid}, 32'd1);
    drive_op(1'b1, 32'h3333, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_3", wb_data, 32'h3333);
    chk("b2b_3rd", {27'b0, wb_rd}, 32'd13);
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("b2b_drain", {31'b0, wb_valid}, 32'd0);

    // Reset mid-access; a late ack must be ignored
    drive_op(1'b1, 32'h400, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive_op(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("rm_req", {31'b0, dmem_req}, 32'd1);
    rst = 1'b1; #1;
    chk("rm_ready_in_rst", {31'b0, ex_ready}, 32'd0);
    tick();
    chk("rm_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("rm_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rm_ex_ready", {31'b0, ex_ready}, 32'd0);
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 1'b0;
    chk("late_ack_wb", {31'b0, wb_valid}, 32'd0);
    chk("late_ack_req", {31'b0, dmem_req}, 32'd0);
    chk("late_ack_ready", {31'b0, ex_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
